// File: rtl/reorder_tag_tracker.sv
// reorder_tag_tracker
//
// Bookkeeping stage that sits beside circular_buffer. It hands out reorder
// tags to packets entering the filter array in strict round-robin order. It
// records each filter's accept/reject verdict per tag. It drives the buffer's
// packet_status for the tag the buffer currently presents. A tag goes back to
// the free pool once the buffer reports that the packet has left.
//
// Ports:
//   clk              rising-edge clock
//   rst              asynchronous, active-low reset
//   alloc_req        upstream wants a tag for a new packet
//   alloc_gnt        tag granted this cycle (combinational)
//   alloc_tag        tag being offered; always the round-robin pointer
//   verdict_valid    a filter verdict is present this cycle
//   verdict_tag      tag the verdict applies to
//   verdict_accept   1 = accept, 0 = reject
//   reorder_tag_out  tag the circular_buffer is currently heading with
//   release_valid    buffer finished with the packet at reorder_tag_out
//   packet_status    00 pending/free, 01 rejected, 11 accepted
//   in_flight        number of slots that are not FREE
//   err_verdict      sticky: a verdict hit a non-PENDING or out-of-range tag
//   err_release      sticky: a release hit an undecided or out-of-range tag
module reorder_tag_tracker #(
  parameter int TAG_WIDTH            = 6,
  parameter int CIRCULAR_BUFFER_SIZE = 50,
  parameter int CNT_WIDTH            = $clog2(CIRCULAR_BUFFER_SIZE + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc_req,
  output logic                 alloc_gnt,
  output logic [TAG_WIDTH-1:0] alloc_tag,
  input  logic                 verdict_valid,
  input  logic [TAG_WIDTH-1:0] verdict_tag,
  input  logic                 verdict_accept,
  input  logic [TAG_WIDTH-1:0] reorder_tag_out,
  input  logic                 release_valid,
  output logic [1:0]           packet_status,
  output logic [CNT_WIDTH-1:0] in_flight,
  output logic                 err_verdict,
  output logic                 err_release
);

  // The encoding is chosen so that decided states already equal the
  // packet_status code. Only PENDING has to be masked to 00.
  typedef enum logic [1:0] {
    FREE     = 2'b00,
    REJECTED = 2'b01,
    PENDING  = 2'b10,
    ACCEPTED = 2'b11
  } slot_state_t;

  localparam logic [TAG_WIDTH-1:0] LAST_TAG = TAG_WIDTH'(CIRCULAR_BUFFER_SIZE - 1);

  slot_state_t            slot_q [CIRCULAR_BUFFER_SIZE];
  logic [TAG_WIDTH-1:0]   alloc_ptr;

  slot_state_t            ptr_state;
  slot_state_t            head_state;
  slot_state_t            vtag_state;
  logic                   verdict_ok;
  logic                   release_ok;

  // Decode lookups run by comparison against every slot index instead of by
  // array indexing. A tag at or beyond the table size therefore matches
  // nothing and reads as FREE. That single rule makes out-of-range tags show
  // status 00 and count as illegal for both verdicts and releases.
  always_comb begin
    ptr_state  = FREE;
    head_state = FREE;
    vtag_state = FREE;
    for (int i = 0; i < CIRCULAR_BUFFER_SIZE; i++) begin
      if (alloc_ptr == TAG_WIDTH'(i))       ptr_state  = slot_q[i];
      if (reorder_tag_out == TAG_WIDTH'(i)) head_state = slot_q[i];
      if (verdict_tag == TAG_WIDTH'(i))     vtag_state = slot_q[i];
    end
  end

  // The grant never skips a busy slot; it simply stalls, so tags leave in
  // exactly the order they were issued. A slot being released this cycle is
  // still decided (not FREE), so there is no same-cycle bypass.
  always_comb begin
    alloc_tag     = alloc_ptr;
    alloc_gnt     = alloc_req && (ptr_state == FREE);
    verdict_ok    = verdict_valid && (vtag_state == PENDING);
    release_ok    = release_valid &&
                    ((head_state == ACCEPTED) || (head_state == REJECTED));
    packet_status = (head_state == PENDING) ? 2'b00 : 2'(head_state);
  end

  // Slot table update. Grant, verdict and release are all judged on the
  // pre-edge state. A grant needs FREE, a verdict needs PENDING, and a legal
  // release needs a decided slot. So in any one cycle, no two of these writes
  // can hit the same slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < CIRCULAR_BUFFER_SIZE; i++) slot_q[i] <= FREE;
    end else begin
      for (int i = 0; i < CIRCULAR_BUFFER_SIZE; i++) begin
        if (alloc_gnt && (alloc_ptr == TAG_WIDTH'(i))) begin
          slot_q[i] <= PENDING;
        end
        if (verdict_ok && (verdict_tag == TAG_WIDTH'(i))) begin
          slot_q[i] <= verdict_accept ? ACCEPTED : REJECTED;
        end
        if (release_ok && (reorder_tag_out == TAG_WIDTH'(i))) begin
          slot_q[i] <= FREE;
        end
      end
    end
  end

  // Round-robin pointer, wrapping from the last slot back to tag 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alloc_ptr <= '0;
    end else if (alloc_gnt) begin
      alloc_ptr <= (alloc_ptr == LAST_TAG) ? '0 : alloc_ptr + TAG_WIDTH'(1);
    end
  end

  // Occupancy count. A grant and a legal release in the same cycle cancel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_flight <= '0;
    end else begin
      case ({alloc_gnt, release_ok})
        2'b10:   in_flight <= in_flight + CNT_WIDTH'(1);
        2'b01:   in_flight <= in_flight - CNT_WIDTH'(1);
        default: in_flight <= in_flight;
      endcase
    end
  end

  // Sticky error flags. They clear only on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_verdict <= 1'b0;
      err_release <= 1'b0;
    end else begin
      if (verdict_valid && !verdict_ok) err_verdict <= 1'b1;
      if (release_valid && !release_ok) err_release <= 1'b1;
    end
  end

endmodule
